// File: rtl/wram_port_arbiter.sv
// Shared 8 KB WRAM: arbitrates one BRAM port between the NES CPU strobe bus
// and the IOSys RV toggle req/ack bus, splitting RV words into byte lanes.
module wram_port_arbiter #(
    parameter int          DEPTH       = 8192,
    parameter int          RV_MAX_WAIT = 8,
    parameter logic [15:0] CPU_BASE    = 16'h6000,
    parameter logic [22:0] RV_BASE     = 23'h66000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wram_load_ongoing,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_rd,
    input  logic        i_cpu_wr,
    input  logic [7:0]  i_cpu_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_cpu_rvalid,
    output logic        o_cpu_overflow,
    input  logic [22:0] i_rv_addr,
    input  logic [31:0] i_rv_wdata,
    input  logic [3:0]  i_rv_wstrb,
    input  logic        i_rv_req,
    output logic        o_rv_req_ack,
    output logic [31:0] o_rv_rdata,
    output logic        o_rv_miss
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam int          WAIT_W   = $clog2(RV_MAX_WAIT + 1);
    localparam logic [31:0] CPU_LAST = 32'(CPU_BASE) + 32'(DEPTH) - 32'd1;
    localparam logic [31:0] RV_LAST  = 32'(RV_BASE) + 32'(DEPTH) - 32'd1;

    typedef enum logic [1:0] {
        IDLE,
        RV_LANE,
        RV_DONE
    } arbState_t;

    logic [7:0]        mem [DEPTH];
    logic [7:0]        bramQ;
    logic              bramEn;
    logic              bramWe;
    logic [IDX_W-1:0]  bramAddr;
    logic [7:0]        bramWdata;

    arbState_t         state_q, state_d;
    logic [1:0]        laneCnt_q, laneCnt_d;
    logic [3:0]        laneMask_q;
    logic [IDX_W-3:0]  rvIdx_q;
    logic [31:0]       rvWdata_q;
    logic              rvWrite_q;
    logic              rvReqLvl_q;
    logic              rvMissFlag_q;
    logic              rvAck_q, rvAck_d;
    logic [31:0]       rvRdata_q, rvRdata_d;
    logic              rvMissPulse_q, rvMissPulse_d;
    logic [31:0]       rvBuf_q;
    logic              rvRdPend_q, rvRdPend_d;
    logic [1:0]        rvRdLane_q;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;

    logic              cpuPend_q, cpuPend_d;
    logic              cpuPendWr_q;
    logic [IDX_W-1:0]  cpuPendIdx_q;
    logic [7:0]        cpuPendData_q;
    logic              cpuRvalid_q, cpuRvalid_d;
    logic              cpuOverflow_q, cpuOverflow_d;
    logic [7:0]        cpuHold_q;

    logic              cpuHit;
    logic              cpuNew;
    logic [IDX_W-1:0]  cpuIdx;
    logic              rvHit;
    logic [IDX_W-3:0]  rvWordIdx;
    logic              rvActive;
    logic              cpuReq;
    logic              grantRv;
    logic              grantCpu;
    logic              serveWr;
    logic [IDX_W-1:0]  serveIdx;
    logic [7:0]        serveData;
    logic              rvAccept;
    logic [3:0]        newMask;
    logic [2:0]        firstLane;
    logic [2:0]        nextLane;
    logic [31:0]       rvMerged;

    // Lowest set mask bit at or above start; bit 2 of the result flags "found".
    function automatic logic [2:0] findLane(input logic [3:0] mask, input logic [2:0] start);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= start)) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

    always_comb begin
        cpuHit    = (32'(i_cpu_addr) >= 32'(CPU_BASE)) && (32'(i_cpu_addr) <= CPU_LAST);
        cpuIdx    = IDX_W'(i_cpu_addr - CPU_BASE);
        cpuNew    = (i_cpu_rd | i_cpu_wr) & cpuHit;
        rvHit     = (32'(i_rv_addr) >= 32'(RV_BASE)) && (32'(i_rv_addr) <= RV_LAST);
        rvWordIdx = (IDX_W-2)'((i_rv_addr - RV_BASE) >> 2);
    end

    // A starved or load-priority RV lane beats the CPU; otherwise the CPU wins.
    always_comb begin
        rvActive  = (state_q == RV_LANE);
        cpuReq    = cpuPend_q | cpuNew;
        grantRv   = rvActive & ((waitCnt_q >= WAIT_W'(RV_MAX_WAIT)) | i_wram_load_ongoing | ~cpuReq);
        grantCpu  = cpuReq & ~grantRv;
        serveWr   = cpuPend_q ? cpuPendWr_q   : i_cpu_wr;
        serveIdx  = cpuPend_q ? cpuPendIdx_q  : cpuIdx;
        serveData = cpuPend_q ? cpuPendData_q : i_cpu_wdata;

        bramEn    = 1'b0;
        bramWe    = 1'b0;
        bramAddr  = '0;
        bramWdata = '0;
        if (grantRv) begin
            bramEn    = 1'b1;
            bramWe    = rvWrite_q;
            bramAddr  = {rvIdx_q, laneCnt_q};
            bramWdata = rvWdata_q[{laneCnt_q, 3'b000} +: 8];
        end else if (grantCpu) begin
            bramEn    = 1'b1;
            bramWe    = serveWr;
            bramAddr  = serveIdx;
            bramWdata = serveData;
        end
    end

    // Read-first single-port RAM; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (bramEn) begin
            if (bramWe) begin
                mem[bramAddr] <= bramWdata;
            end
            bramQ <= mem[bramAddr];
        end
    end

    always_comb begin
        rvMerged = rvBuf_q;
        if (rvRdPend_q) begin
            rvMerged[{rvRdLane_q, 3'b000} +: 8] = bramQ;
        end
    end

    always_comb begin
        state_d       = state_q;
        laneCnt_d     = laneCnt_q;
        rvAck_d       = rvAck_q;
        rvRdata_d     = rvRdata_q;
        rvMissPulse_d = 1'b0;
        rvAccept      = 1'b0;
        newMask       = (|i_rv_wstrb) ? i_rv_wstrb : 4'hF;
        firstLane     = findLane(newMask, 3'd0);
        nextLane      = findLane(laneMask_q, {1'b0, laneCnt_q} + 3'd1);

        case (state_q)
            IDLE: begin
                if (i_rv_req != rvAck_q) begin
                    rvAccept = 1'b1;
                    if (rvHit && firstLane[2]) begin
                        state_d   = RV_LANE;
                        laneCnt_d = firstLane[1:0];
                    end else begin
                        state_d = RV_DONE;
                    end
                end
            end
            RV_LANE: begin
                if (grantRv) begin
                    if (nextLane[2]) begin
                        laneCnt_d = nextLane[1:0];
                    end else begin
                        state_d = RV_DONE;
                    end
                end
            end
            RV_DONE: begin
                state_d       = IDLE;
                laneCnt_d     = 2'd0;
                rvAck_d       = rvReqLvl_q;
                rvMissPulse_d = rvMissFlag_q;
                if (rvMissFlag_q) begin
                    rvRdata_d = '0;
                end else if (!rvWrite_q) begin
                    rvRdata_d = rvMerged;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (!rvActive || grantRv) begin
            waitCnt_d = '0;
        end else if (waitCnt_q < WAIT_W'(RV_MAX_WAIT)) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end else begin
            waitCnt_d = waitCnt_q;
        end
        cpuPend_d     = cpuPend_q ? ~grantCpu : (cpuNew & ~grantCpu);
        cpuOverflow_d = cpuOverflow_q | (cpuPend_q & cpuNew);
        cpuRvalid_d   = grantCpu & ~serveWr;
        rvRdPend_d    = grantRv & ~rvWrite_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            laneCnt_q     <= '0;
            laneMask_q    <= '0;
            rvIdx_q       <= '0;
            rvWdata_q     <= '0;
            rvWrite_q     <= 1'b0;
            rvReqLvl_q    <= 1'b0;
            rvMissFlag_q  <= 1'b0;
            rvAck_q       <= 1'b0;
            rvRdata_q     <= '0;
            rvMissPulse_q <= 1'b0;
            rvBuf_q       <= '0;
            rvRdPend_q    <= 1'b0;
            rvRdLane_q    <= '0;
            waitCnt_q     <= '0;
            cpuPend_q     <= 1'b0;
            cpuPendWr_q   <= 1'b0;
            cpuPendIdx_q  <= '0;
            cpuPendData_q <= '0;
            cpuRvalid_q   <= 1'b0;
            cpuOverflow_q <= 1'b0;
            cpuHold_q     <= '0;
        end else begin
            state_q       <= state_d;
            laneCnt_q     <= laneCnt_d;
            rvAck_q       <= rvAck_d;
            rvRdata_q     <= rvRdata_d;
            rvMissPulse_q <= rvMissPulse_d;
            rvBuf_q       <= rvMerged;
            rvRdPend_q    <= rvRdPend_d;
            waitCnt_q     <= waitCnt_d;
            cpuPend_q     <= cpuPend_d;
            cpuRvalid_q   <= cpuRvalid_d;
            cpuOverflow_q <= cpuOverflow_d;
            if (rvAccept) begin
                laneMask_q   <= newMask;
                rvIdx_q      <= rvWordIdx;
                rvWdata_q    <= i_rv_wdata;
                rvWrite_q    <= |i_rv_wstrb;
                rvReqLvl_q   <= i_rv_req;
                rvMissFlag_q <= ~rvHit;
            end
            if (grantRv) begin
                rvRdLane_q <= laneCnt_q;
            end
            if (!cpuPend_q && cpuNew && !grantCpu) begin
                cpuPendWr_q   <= i_cpu_wr;
                cpuPendIdx_q  <= cpuIdx;
                cpuPendData_q <= i_cpu_wdata;
            end
            if (cpuRvalid_q) begin
                cpuHold_q <= bramQ;
            end
        end
    end

    // The read byte is shown straight from the RAM during the valid pulse, then held.
    assign o_cpu_rdata    = cpuRvalid_q ? bramQ : cpuHold_q;
    assign o_cpu_rvalid   = cpuRvalid_q;
    assign o_cpu_overflow = cpuOverflow_q;
    assign o_rv_req_ack   = rvAck_q;
    assign o_rv_rdata     = rvRdata_q;
    assign o_rv_miss      = rvMissPulse_q;

endmodule

// File: tb/tb_wram_port_arbiter.sv
// Directed bench for wram_port_arbiter: CPU access, RV lane sequencing,
// starvation guard, load priority, overflow, window misses and reset abort.
module tb_wram_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_wram_load_ongoing;
    logic [15:0] i_cpu_addr;
    logic        i_cpu_rd;
    logic        i_cpu_wr;
    logic [7:0]  i_cpu_wdata;
    logic [7:0]  o_cpu_rdata;
    logic        o_cpu_rvalid;
    logic        o_cpu_overflow;
    logic [22:0] i_rv_addr;
    logic [31:0] i_rv_wdata;
    logic [3:0]  i_rv_wstrb;
    logic        i_rv_req;
    logic        o_rv_req_ack;
    logic [31:0] o_rv_rdata;
    logic        o_rv_miss;

    int testsRun = 0;
    int testsFailed = 0;
    int lat;

    wram_port_arbiter dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_wram_load_ongoing (i_wram_load_ongoing),
        .i_cpu_addr          (i_cpu_addr),
        .i_cpu_rd            (i_cpu_rd),
        .i_cpu_wr            (i_cpu_wr),
        .i_cpu_wdata         (i_cpu_wdata),
        .o_cpu_rdata         (o_cpu_rdata),
        .o_cpu_rvalid        (o_cpu_rvalid),
        .o_cpu_overflow      (o_cpu_overflow),
        .i_rv_addr           (i_rv_addr),
        .i_rv_wdata          (i_rv_wdata),
        .i_rv_wstrb          (i_rv_wstrb),
        .i_rv_req            (i_rv_req),
        .o_rv_req_ack        (o_rv_req_ack),
        .o_rv_rdata          (o_rv_rdata),
        .o_rv_miss           (o_rv_miss)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic stepClock();
        @(posedge i_clk);
        #1;
    endtask

    task automatic resetDut();
        i_reset = 1'b1;
        i_rv_req = 1'b0;
        i_cpu_rd = 1'b0;
        i_cpu_wr = 1'b0;
        stepClock();
        stepClock();
        i_reset = 1'b0;
    endtask

    task automatic cpuWrite(input logic [15:0] addr, input logic [7:0] data);
        i_cpu_addr = addr;
        i_cpu_wdata = data;
        i_cpu_wr = 1'b1;
        stepClock();
        i_cpu_wr = 1'b0;
        checkOutput("cpuWrNoRvalid", 32'(o_cpu_rvalid), 32'd0);
    endtask

    task automatic cpuRead(input string tag, input logic [15:0] addr, input logic [7:0] expected);
        i_cpu_addr = addr;
        i_cpu_rd = 1'b1;
        stepClock();
        i_cpu_rd = 1'b0;
        checkOutput({tag, "Rvalid"}, 32'(o_cpu_rvalid), 32'd1);
        checkOutput({tag, "Data"}, 32'(o_cpu_rdata), 32'(expected));
    endtask

    task automatic waitAck(output int cycles);
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            stepClock();
            cycles++;
            if (o_rv_req_ack == i_rv_req) break;
        end
        checkOutput("rvAckSeen", 32'(o_rv_req_ack), 32'(i_rv_req));
    endtask

    // Latency is counted in edges after the one that detects the toggle.
    task automatic rvRequest(input logic [22:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                             output int cycles);
        i_rv_addr = addr;
        i_rv_wdata = wdata;
        i_rv_wstrb = wstrb;
        i_rv_req = ~i_rv_req;
        stepClock();
        waitAck(cycles);
    endtask

    initial begin
        i_reset = 1'b1;
        i_wram_load_ongoing = 1'b0;
        i_cpu_addr = '0;
        i_cpu_rd = 1'b0;
        i_cpu_wr = 1'b0;
        i_cpu_wdata = '0;
        i_rv_addr = '0;
        i_rv_wdata = '0;
        i_rv_wstrb = '0;
        i_rv_req = 1'b0;
        resetDut();

        checkOutput("rstCpuRdata", 32'(o_cpu_rdata), 32'd0);
        checkOutput("rstCpuRvalid", 32'(o_cpu_rvalid), 32'd0);
        checkOutput("rstOverflow", 32'(o_cpu_overflow), 32'd0);
        checkOutput("rstAck", 32'(o_rv_req_ack), 32'd0);
        checkOutput("rstRvRdata", o_rv_rdata, 32'd0);
        checkOutput("rstMiss", 32'(o_rv_miss), 32'd0);

        cpuWrite(16'h6010, 8'hA5);
        cpuRead("cpuRd6010", 16'h6010, 8'hA5);
        cpuWrite(16'h6000, 8'h77);
        cpuWrite(16'h7FFF, 8'h3C);
        cpuWrite(16'h8000, 8'h5A);
        cpuRead("cpuRd6000", 16'h6000, 8'h77);
        cpuRead("cpuRd7FFF", 16'h7FFF, 8'h3C);
        i_cpu_addr = 16'h8000;
        i_cpu_rd = 1'b1;
        stepClock();
        i_cpu_rd = 1'b0;
        checkOutput("cpuRdOutside", 32'(o_cpu_rvalid), 32'd0);

        rvRequest(23'h66010, 32'h44332211, 4'b1111, lat);
        checkOutput("rvWr4Latency", 32'(lat), 32'd5);
        cpuRead("afterWr4b0", 16'h6010, 8'h11);
        cpuRead("afterWr4b1", 16'h6011, 8'h22);
        cpuRead("afterWr4b2", 16'h6012, 8'h33);
        cpuRead("afterWr4b3", 16'h6013, 8'h44);

        rvRequest(23'h66010, 32'h00EE0000, 4'b0100, lat);
        checkOutput("rvWr1Latency", 32'(lat), 32'd2);
        cpuRead("afterWr1b1", 16'h6011, 8'h22);
        cpuRead("afterWr1b2", 16'h6012, 8'hEE);
        cpuRead("afterWr1b3", 16'h6013, 8'h44);

        // CPU strobes every cycle: each lane waits 8 losses, forced on the 9th.
        i_cpu_addr = 16'h6000;
        i_cpu_rd = 1'b1;
        rvRequest(23'h66010, 32'h0, 4'b0000, lat);
        i_cpu_rd = 1'b0;
        checkOutput("starveLatency", 32'(lat), 32'd37);
        checkOutput("starveRdata", o_rv_rdata, 32'h44EE2211);

        resetDut();
        checkOutput("rst2Overflow", 32'(o_cpu_overflow), 32'd0);

        i_wram_load_ongoing = 1'b1;
        i_rv_addr = 23'h66010;
        i_rv_wstrb = 4'b0000;
        i_rv_req = ~i_rv_req;
        stepClock();
        stepClock();
        stepClock();
        stepClock();
        checkOutput("loadAckPending", 32'(o_rv_req_ack), 32'd0);
        i_cpu_addr = 16'h6012;
        i_cpu_rd = 1'b1;
        stepClock();
        checkOutput("loadCpuDeferred", 32'(o_cpu_rvalid), 32'd0);
        stepClock();
        i_cpu_rd = 1'b0;
        checkOutput("loadCpuRvalid", 32'(o_cpu_rvalid), 32'd1);
        checkOutput("loadCpuData", 32'(o_cpu_rdata), 32'h0000_00EE);
        checkOutput("loadOverflow", 32'(o_cpu_overflow), 32'd1);
        checkOutput("loadAck", 32'(o_rv_req_ack), 32'(i_rv_req));
        checkOutput("loadRvRdata", o_rv_rdata, 32'h44EE2211);
        stepClock();
        checkOutput("loadRvalidPulse", 32'(o_cpu_rvalid), 32'd0);
        checkOutput("overflowSticky", 32'(o_cpu_overflow), 32'd1);
        i_wram_load_ongoing = 1'b0;

        rvRequest(23'h10000, 32'h0, 4'b0000, lat);
        checkOutput("missLatency", 32'(lat), 32'd1);
        checkOutput("missPulse", 32'(o_rv_miss), 32'd1);
        checkOutput("missRdata", o_rv_rdata, 32'd0);
        stepClock();
        checkOutput("missPulseEnd", 32'(o_rv_miss), 32'd0);

        rvRequest(23'h67FFC, 32'h5A000000, 4'b1000, lat);
        checkOutput("topLaneLatency", 32'(lat), 32'd2);
        checkOutput("topLaneNoMiss", 32'(o_rv_miss), 32'd0);
        cpuRead("cpuRdTop", 16'h7FFF, 8'h5A);

        rvRequest(23'h68000, 32'h0, 4'b0000, lat);
        checkOutput("missAboveLatency", 32'(lat), 32'd1);
        checkOutput("missAbovePulse", 32'(o_rv_miss), 32'd1);

        // Abort a read after lane 0; req stays high so it restarts after reset.
        i_rv_addr = 23'h66010;
        i_rv_wstrb = 4'b0000;
        i_rv_req = ~i_rv_req;
        stepClock();
        stepClock();
        i_reset = 1'b1;
        stepClock();
        checkOutput("abortAck", 32'(o_rv_req_ack), 32'd0);
        checkOutput("abortRvRdata", o_rv_rdata, 32'd0);
        checkOutput("abortMiss", 32'(o_rv_miss), 32'd0);
        checkOutput("abortOverflow", 32'(o_cpu_overflow), 32'd0);
        checkOutput("abortRvalid", 32'(o_cpu_rvalid), 32'd0);
        checkOutput("abortCpuRdata", 32'(o_cpu_rdata), 32'd0);
        i_reset = 1'b0;
        stepClock();
        waitAck(lat);
        checkOutput("restartLatency", 32'(lat), 32'd5);
        checkOutput("restartRdata", o_rv_rdata, 32'h44EE2211);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wram_port_arbiter.md
Name: wram_port_arbiter

Overview:
Owns the 8 KB WRAM block RAM shared by the NES CPU ($6000-$7FFF) and the IOSys RISC-V core ($66000-$67FFF). It grants a single BSRAM port each cycle between a CPU strobe interface and an RV toggle req/ack interface. RV 32-bit accesses are sequenced one byte lane at a time. Priority is CPU-first, except during a WRAM load from RV and when the RV starvation guard fires.

Parameters:
DEPTH, 8192, WRAM bytes; index width = log2(DEPTH) = 13
RV_MAX_WAIT, 8, cycles an RV lane may wait before it is forced ahead of the CPU
CPU_BASE, 16'h6000, CPU window base
RV_BASE, 23'h66000, RV window base

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous reset, active-high
i_wram_load_ongoing  in  1  1 = RV has priority (save-state load)
i_cpu_addr  in  16  CPU byte address
i_cpu_rd  in  1  one-cycle read strobe
i_cpu_wr  in  1  one-cycle write strobe
i_cpu_wdata  in  8  CPU write byte
o_cpu_rdata  out  8  CPU read byte
o_cpu_rvalid  out  1  one-cycle pulse when o_cpu_rdata is valid
o_cpu_overflow  out  1  sticky; set when a CPU strobe is lost
i_rv_addr  in  23  RV byte address; bits [1:0] ignored
i_rv_wdata  in  32  RV write word
i_rv_wstrb  in  4  byte write enables; 0 = read of all 4 lanes
i_rv_req  in  1  toggle request
o_rv_req_ack  out  1  toggle acknowledge
o_rv_rdata  out  32  RV read word
o_rv_miss  out  1  one-cycle pulse when an RV request falls outside the window

Behaviour:
- Reset values: o_cpu_rdata=0, o_cpu_rvalid=0, o_cpu_overflow=0, o_rv_req_ack=0, o_rv_rdata=0, o_rv_miss=0. Internal state: lane counter 0, CPU pending 0, wait counter 0, FSM in IDLE. BRAM contents are untouched.
- Reset mid-operation aborts any RV sequence; no ack is issued. If i_rv_req=1 when reset releases, it is a new request.
- CPU hit: CPU_BASE <= addr <= CPU_BASE+DEPTH-1, index = addr-CPU_BASE. A strobe outside the window is ignored.
- RV hit: RV_BASE <= addr <= RV_BASE+DEPTH-1, index = {addr[12:2], lane}.
- New RV request: i_rv_req != o_rv_req_ack while in IDLE. Latch addr, wdata, wstrb and the req level, then go to RV_LANE.
- RV miss: ack 1 cycle after detection with o_rv_rdata=0 and o_rv_miss pulsed; no BRAM access.
- FSM states: IDLE, RV_LANE, RV_DONE.
  - RV_LANE steps through lanes 0..3. For writes, lanes with a clear strobe bit are skipped and cost 0 cycles.
  - After the last active lane, go to RV_DONE. RV_DONE captures the final read byte, sets o_rv_req_ack to the latched req level, and returns to IDLE.
  - RV request to ack latency without contention: read = 5 cycles; write = number of set strobes + 1.
- CPU request buffer: one-deep pending register.
  - A strobe arriving while one is already pending sets o_cpu_overflow; the new strobe is dropped.
  - A simultaneous i_cpu_rd and i_cpu_wr is treated as a write.
- Per-cycle grant of the single BRAM port:
  - Force RV if wait counter >= RV_MAX_WAIT and an RV lane is active.
  - Otherwise RV if i_wram_load_ongoing and an RV lane is active.
  - Otherwise CPU if a CPU request (new or pending) exists.
  - Otherwise RV lane.
- Wait counter: increments each cycle an active RV lane loses the grant, clears on an RV grant, and saturates at RV_MAX_WAIT.
- CPU read latency: granted in cycle N → o_cpu_rdata/o_cpu_rvalid in cycle N+1. Each cycle of deferral adds 1.
- CPU writes produce no rvalid.
- BRAM reads are synchronous, 1 cycle. Read-during-write to the same index returns the old data.
- o_cpu_rvalid and o_rv_miss are single-cycle pulses.

Test Plan:
- CPU wr $6010=8'hA5, then rd $6010 → o_cpu_rvalid in the cycle after the read grant, rdata=8'hA5. Write to $8000 → BRAM unchanged, no rvalid.
- RV write addr 23'h66010, wdata 32'h44332211, wstrb 4'b1111, toggle req → ack after 5 cycles. CPU reads of $6010..$6013 return 11,22,33,44.
- RV write wstrb 4'b0100, wdata 32'h00EE0000 at 23'h66010 → only $6012 becomes EE; ack after 2 cycles.
- RV read at 23'h66010 with a CPU strobe every cycle, load_ongoing=0 → RV is forced every 9th cycle, the ack still arrives, and rdata equals the current bytes.
- load_ongoing=1, RV read in progress, CPU read strobe → CPU is deferred 1 cycle (rvalid at N+2). A second strobe while the first is pending → o_cpu_overflow=1 and stays set.
- RV req at 23'h10000 → o_rv_miss pulse, ack after 1 cycle, o_rv_rdata=0. Assert i_reset mid-sequence → ack does not toggle and all outputs return to 0.
